// File: rtl/mem_access_if.sv
// Avalon-style data bus between the load/store unit (master) and memory (slave).
interface mem_access_if;
  logic [31:0] address_o;
  logic        read_o;
  logic        write_o;
  logic [3:0]  byteenable_o;
  logic [31:0] writedata_o;
  logic [31:0] readdata_i;
  logic        waitrequest_i;

  modport master (
    output address_o,
    output read_o,
    output write_o,
    output byteenable_o,
    output writedata_o,
    input  readdata_i,
    input  waitrequest_i
  );

  modport slave (
    input  address_o,
    input  read_o,
    input  write_o,
    input  byteenable_o,
    input  writedata_o,
    output readdata_i,
    output waitrequest_i
  );
endinterface

// File: rtl/mem_access.sv
// Multi-cycle load/store unit: one bus access per accepted start, with wait-state timeout.
// Optional misalignment trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [5:0]   opcode_i,
  input  logic [31:0]  effective_address_i,
  input  logic [31:0]  rt_i,
  output logic         stall_o,
  output logic         done_o,
  output logic [31:0]  load_data_o,
  output logic         bus_error_o,
  output logic         addr_error_o,
  mem_access_if.master bus
);

  typedef enum logic [5:0] {
    OpLb  = 6'h20,
    OpLh  = 6'h21,
    OpLw  = 6'h23,
    OpLbu = 6'h24,
    OpLhu = 6'h25,
    OpSb  = 6'h28,
    OpSh  = 6'h29,
    OpSw  = 6'h2B
  } opcode_t;

  typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_e;
  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  // Counter holds completed wait cycles minus one at the point of timeout.
  localparam int unsigned CntW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CntW-1:0] WaitLast = CntW'(MAX_WAIT - 1);

  state_e          state_q, state_d;
  logic [29:0]     addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     wdata_q, wdata_d;
  size_e           size_q, size_d;
  logic            signed_q, signed_d;
  logic            load_q, load_d;
  logic [1:0]      offset_q, offset_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]     load_data_q, load_data_d;
  logic            bus_error_q, bus_error_d;
`ifdef MEM_ALIGN_CHECK_EN
  logic            addr_error_q, addr_error_d;
  logic            dec_misalign;
`endif

  logic        dec_mem;
  logic        dec_load;
  logic        dec_signed;
  size_e       dec_size;
  logic [3:0]  dec_be;
  logic [31:0] dec_wdata;

  always_comb begin
    dec_mem    = 1'b1;
    dec_load   = 1'b0;
    dec_signed = 1'b0;
    dec_size   = SzWord;
    case (opcode_i)
      OpLb:    begin dec_load = 1'b1; dec_signed = 1'b1; dec_size = SzByte; end
      OpLh:    begin dec_load = 1'b1; dec_signed = 1'b1; dec_size = SzHalf; end
      OpLw:    begin dec_load = 1'b1; dec_size = SzWord; end
      OpLbu:   begin dec_load = 1'b1; dec_size = SzByte; end
      OpLhu:   begin dec_load = 1'b1; dec_size = SzHalf; end
      OpSb:    dec_size = SzByte;
      OpSh:    dec_size = SzHalf;
      OpSw:    dec_size = SzWord;
      default: dec_mem = 1'b0;
    endcase

    case (dec_size)
      SzByte: begin
        dec_be    = 4'b0001 << effective_address_i[1:0];
        dec_wdata = {4{rt_i[7:0]}};
      end
      SzHalf: begin
        dec_be    = effective_address_i[1] ? 4'b1100 : 4'b0011;
        dec_wdata = {2{rt_i[15:0]}};
      end
      default: begin
        dec_be    = 4'b1111;
        dec_wdata = rt_i;
      end
    endcase
`ifdef MEM_ALIGN_CHECK_EN
    dec_misalign = ((dec_size == SzHalf) && effective_address_i[0]) ||
                   ((dec_size == SzWord) && (effective_address_i[1:0] != 2'b00));
`endif
  end

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_ext;

  always_comb begin
    case (offset_q)
      2'd0:    lane_byte = bus.readdata_i[7:0];
      2'd1:    lane_byte = bus.readdata_i[15:8];
      2'd2:    lane_byte = bus.readdata_i[23:16];
      default: lane_byte = bus.readdata_i[31:24];
    endcase
    lane_half = offset_q[1] ? bus.readdata_i[31:16] : bus.readdata_i[15:0];
    case (size_q)
      SzByte:  load_ext = signed_q ? {{24{lane_byte[7]}}, lane_byte} : {24'h0, lane_byte};
      SzHalf:  load_ext = signed_q ? {{16{lane_half[15]}}, lane_half} : {16'h0, lane_half};
      default: load_ext = bus.readdata_i;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    size_d       = size_q;
    signed_d     = signed_q;
    load_d       = load_q;
    offset_d     = offset_q;
    wait_cnt_d   = wait_cnt_q;
    load_data_d  = load_data_q;
    bus_error_d  = bus_error_q;
`ifdef MEM_ALIGN_CHECK_EN
    addr_error_d = addr_error_q;
`endif
    stall_o      = 1'b0;

    case (state_q)
      StIdle: begin
        if (start_i && dec_mem) begin
          stall_o     = 1'b1;
          addr_d      = effective_address_i[31:2];
          be_d        = dec_be;
          wdata_d     = dec_wdata;
          size_d      = dec_size;
          signed_d    = dec_signed;
          load_d      = dec_load;
          offset_d    = effective_address_i[1:0];
          wait_cnt_d  = '0;
          bus_error_d = 1'b0;
          state_d     = StAccess;
`ifdef MEM_ALIGN_CHECK_EN
          addr_error_d = 1'b0;
          if (dec_misalign) begin
            // Trap without touching the bus.
            addr_error_d = 1'b1;
            state_d      = StDone;
            if (dec_load) begin
              load_data_d = 32'h0;
            end
          end
`endif
        end
      end
      StAccess: begin
        stall_o = 1'b1;
        if (!bus.waitrequest_i) begin
          state_d = StDone;
          if (load_q) begin
            load_data_d = load_ext;
          end
        end else if (wait_cnt_q == WaitLast) begin
          state_d     = StDone;
          bus_error_d = 1'b1;
          if (load_q) begin
            load_data_d = 32'h0;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      size_q      <= SzByte;
      signed_q    <= 1'b0;
      load_q      <= 1'b0;
      offset_q    <= '0;
      wait_cnt_q  <= '0;
      load_data_q <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      load_q      <= load_d;
      offset_q    <= offset_d;
      wait_cnt_q  <= wait_cnt_d;
      load_data_q <= load_data_d;
      bus_error_q <= bus_error_d;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_error_q <= 1'b0;
    end else begin
      addr_error_q <= addr_error_d;
    end
  end
  assign addr_error_o = addr_error_q;
`else
  assign addr_error_o = 1'b0;
`endif

  // Strobes are decoded from state so reset removes them without waiting for a clock.
  assign bus.read_o       = (state_q == StAccess) && load_q;
  assign bus.write_o      = (state_q == StAccess) && !load_q;
  assign bus.address_o    = {addr_q, 2'b00};
  assign bus.byteenable_o = be_q;
  assign bus.writedata_o  = wdata_q;
  assign done_o           = (state_q == StDone);
  assign load_data_o      = load_data_q;
  assign bus_error_o      = bus_error_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: timeline model of each access plus literal spot checks.
module tb_mem_access;
  localparam int unsigned MaxWait = 4;
  localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24, LHU = 6'h25;
  localparam logic [5:0] SB = 6'h28, SH = 6'h29, SW = 6'h2B;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [5:0]  opcode_i = '0;
  logic [31:0] effective_address_i = '0;
  logic [31:0] rt_i = '0;
  logic        stall_o, done_o, bus_error_o, addr_error_o;
  logic [31:0] load_data_o;

  mem_access_if bus_if ();

  mem_access #(.MAX_WAIT(MaxWait)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start_i             (start_i),
    .opcode_i            (opcode_i),
    .effective_address_i (effective_address_i),
    .rt_i                (rt_i),
    .stall_o             (stall_o),
    .done_o              (done_o),
    .load_data_o         (load_data_o),
    .bus_error_o         (bus_error_o),
    .addr_error_o        (addr_error_o),
    .bus                 (bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Timeline model of the access in flight.
  bit          m_active = 1'b0;
  int          m_k = 0;
  int          m_nstrobe = 0;
  bit          m_load = 1'b0;
  logic [31:0] m_addr = '0;
  logic [3:0]  m_be = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_ld = '0;
  bit          m_berr = 1'b0;
  bit          m_aerr = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int op_bytes(input logic [5:0] op);
    case (op)
      LB, LBU, SB: return 1;
      LH, LHU, SH: return 2;
      LW, SW:      return 4;
      default:     return 0;
    endcase
  endfunction

  function automatic int lane_off(input logic [31:0] ea, input int n);
    return (int'(ea[1:0]) / n) * n;
  endfunction

  function automatic logic [31:0] f_load(input logic [5:0] op, input logic [31:0] ea,
                                         input logic [31:0] rd);
    int n;
    longint span, v;
    n    = op_bytes(op);
    span = longint'(1) << (8 * n);
    v    = (longint'(rd) >> (8 * lane_off(ea, n))) % span;
    if ((op == LB || op == LH) && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (m_active) begin
        bit strobe;
        strobe = (m_k <= m_nstrobe);
        chk("read_o", 32'(bus_if.read_o), 32'(strobe && m_load));
        chk("write_o", 32'(bus_if.write_o), 32'(strobe && !m_load));
        chk("stall_o", 32'(stall_o), 32'(strobe));
        chk("done_o", 32'(done_o), 32'(m_k == m_nstrobe + 1));
        if (strobe) begin
          chk("address_o", bus_if.address_o, m_addr);
          chk("byteenable_o", 32'(bus_if.byteenable_o), 32'(m_be));
          if (!m_load) chk("writedata_o", bus_if.writedata_o, m_wdata);
        end
        if (m_k == m_nstrobe + 1) begin
          chk("bus_error_o", 32'(bus_error_o), 32'(m_berr));
          chk("addr_error_o", 32'(addr_error_o), 32'(m_aerr));
          chk("load_data_o", load_data_o, m_ld);
        end
      end
    end
  end

  // w: waitrequest cycles before acceptance; stuck: never accepted; hold: keep start high.
  task automatic run_op(input logic [5:0] op, input logic [31:0] ea, input logic [31:0] rt,
                        input logic [31:0] rd, input int w, input bit stuck, input bit hold);
    int  n;
    bit  misal;
    n = op_bytes(op);
    @(negedge clk);
    start_i = 1'b1;
    opcode_i = op;
    effective_address_i = ea;
    rt_i = rt;
    bus_if.readdata_i = rd;
    bus_if.waitrequest_i = 1'b1;
    m_load  = (op < SB);
    m_addr  = ea & 32'hFFFF_FFFC;
    m_be    = 4'(((1 << n) - 1) << lane_off(ea, n));
    m_wdata = (n == 1) ? rt[7:0] * 32'h0101_0101 :
              (n == 2) ? rt[15:0] * 32'h0001_0001 : rt;
`ifdef MEM_ALIGN_CHECK_EN
    misal = (int'(ea[1:0]) % n) != 0;
`else
    misal = 1'b0;
`endif
    m_aerr = misal;
    m_berr = stuck && !misal;
    if (misal) m_nstrobe = 0;
    else if (stuck) m_nstrobe = MaxWait;
    else m_nstrobe = w + 1;
    if (m_load) m_ld = (misal || stuck) ? 32'h0 : f_load(op, ea, rd);
    #1;
    chk("stall_o_at_start", 32'(stall_o), 32'h1);
    @(posedge clk);
    #1;
    m_k = 1;
    m_active = 1'b1;
    start_i = hold;
    if (hold) begin
      opcode_i = SB;
      effective_address_i = 32'h0000_03FD;
      rt_i = 32'hFFFF_FFFF;
    end
    bus_if.waitrequest_i = stuck || (m_k <= w);
    while (m_k <= m_nstrobe + 1) begin
      @(posedge clk);
      #1;
      m_k++;
      bus_if.waitrequest_i = stuck || (m_k <= w);
    end
    m_active = 1'b0;
    start_i = 1'b0;
    bus_if.waitrequest_i = 1'b0;
  endtask

  initial begin
    bus_if.readdata_i = '0;
    bus_if.waitrequest_i = 1'b0;
    #2;
    chk("rst_stall", 32'(stall_o), 32'h0);
    chk("rst_done", 32'(done_o), 32'h0);
    chk("rst_load_data", load_data_o, 32'h0);
    chk("rst_bus_error", 32'(bus_error_o), 32'h0);
    chk("rst_addr_error", 32'(addr_error_o), 32'h0);
    chk("rst_address", bus_if.address_o, 32'h0);
    chk("rst_read", 32'(bus_if.read_o), 32'h0);
    chk("rst_write", 32'(bus_if.write_o), 32'h0);
    chk("rst_byteenable", 32'(bus_if.byteenable_o), 32'h0);
    chk("rst_writedata", bus_if.writedata_o, 32'h0);
    #20;
    rst_n = 1'b1;

    run_op(LW, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 1'b0, 1'b0);
    chk("lw_literal", load_data_o, 32'hDEAD_BEEF);
    run_op(LB, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0, 1'b0, 1'b0);
    chk("lb_literal", load_data_o, 32'hFFFF_FF80);
    chk("lb_be_literal", 32'(bus_if.byteenable_o), 32'h8);
    run_op(LBU, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0, 1'b0, 1'b0);
    chk("lbu_literal", load_data_o, 32'h0000_0080);
    run_op(SH, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 3, 1'b0, 1'b0);
    chk("sh_wdata_literal", bus_if.writedata_o, 32'hABCD_ABCD);
    chk("sh_be_literal", 32'(bus_if.byteenable_o), 32'hC);
    chk("store_keeps_load_data", load_data_o, 32'h0000_0080);
    run_op(LH, 32'h0000_0102, 32'h0, 32'h8001_7FFF, 1, 1'b0, 1'b0);
    chk("lh_literal", load_data_o, 32'hFFFF_8001);
    run_op(LHU, 32'h0000_0100, 32'h0, 32'h8001_7FFF, 0, 1'b0, 1'b0);
    chk("lhu_literal", load_data_o, 32'h0000_7FFF);
    run_op(SB, 32'h0000_0201, 32'h1234_5678, 32'h0, 0, 1'b0, 1'b1);
    chk("sb_wdata_literal", bus_if.writedata_o, 32'h7878_7878);
    run_op(SW, 32'h0000_0300, 32'hCAFE_F00D, 32'h0, 2, 1'b0, 1'b1);
    run_op(LW, 32'h0000_0104, 32'h0, 32'h1111_2222, 0, 1'b1, 1'b0);
    chk("timeout_bus_error_held", 32'(bus_error_o), 32'h1);
    chk("timeout_load_zero", load_data_o, 32'h0);
    run_op(LW, 32'h0000_0108, 32'h0, 32'h3333_4444, 0, 1'b0, 1'b0);
    run_op(LW, 32'h0000_0101, 32'h0, 32'h5555_6666, 0, 1'b0, 1'b0);
    run_op(LHU, 32'h0000_0103, 32'h0, 32'hA5B6_C7D8, 0, 1'b0, 1'b0);

    // Non-memory opcode must be ignored.
    @(negedge clk);
    start_i = 1'b1;
    opcode_i = 6'h00;
    #1;
    chk("nonmem_stall", 32'(stall_o), 32'h0);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("nonmem_strobe", 32'(bus_if.read_o | bus_if.write_o | done_o), 32'h0);
    end

    // Asynchronous reset in the middle of a store.
    @(negedge clk);
    start_i = 1'b1;
    opcode_i = SW;
    effective_address_i = 32'h0000_0400;
    rt_i = 32'h1122_3344;
    bus_if.waitrequest_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    @(posedge clk);
    #3;
    chk("sw_write_before_reset", 32'(bus_if.write_o), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("reset_write_drop", 32'(bus_if.write_o), 32'h0);
    chk("reset_stall_drop", 32'(stall_o), 32'h0);
    chk("reset_address_clear", bus_if.address_o, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus_if.waitrequest_i = 1'b0;
    m_ld = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_no_done", 32'(done_o | bus_if.write_o), 32'h0);
    end
    run_op(LW, 32'h0000_0500, 32'h0, 32'h0BAD_F00D, 1, 1'b0, 1'b0);
    chk("after_reset_lw", load_data_o, 32'h0BAD_F00D);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
